mitll_splitter_n: RTL and testbench
===================================

MITLL_SPLITTER_N -- requirements
Module: mitll_splitter_n

Interface
REQ-001 SHALL have parameter N_OUT, default 4, number of fan-out outputs (legal 2..16).
REQ-002 SHALL have parameter DLY_W, default 4, width of each per-output delay field; MAX_DLY = 2^DLY_W-1 cycles.
REQ-003 SHALL have parameter CT_W, default 4, width of critical-timing window field.
REQ-004 SHALL have parameter STARTUP_CYC, default 4, cycles after reset during which input events are ignored.
REQ-005 SHALL have port clk  input  1  timing-reference clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in  input  1  toggle-encoded SFQ pulse input; each level change is one pulse.
REQ-008 SHALL have port dly_cfg  input  N_OUT*DLY_W  per-output delay in cycles, field i drives out[i].
REQ-009 SHALL have port ct_cfg  input  CT_W  critical-timing window in cycles; 0 disables checking.
REQ-010 SHALL have port err_clr  input  1  single-cycle request to leave ERROR.
REQ-011 SHALL have port out  output  N_OUT  toggle-encoded output pulses, one bit per branch.
REQ-012 SHALL have port err  output  1  high while in ERROR state.
REQ-013 SHALL have port err_cnt  output  8  saturating count of timing violations.
REQ-014 SHALL have port busy  output  1  high while any accepted event is still in flight.

Function
REQ-015 SHALL sample in every edge; event at edge k when sample at k differs from sample at k-1.
REQ-016 SHALL toggle out[i] at edge k+D_i for an accepted event at edge k, D_i = dly_cfg field i, field value 0 treated as 1.
REQ-017 SHALL support multiple events in flight simultaneously; each produces exactly one toggle per output, in order.
REQ-018 SHALL use dly_cfg value current at output time (delay-line tap select); mid-flight changes may drop or duplicate pulses, not checked.
REQ-019 SHALL implement states WARMUP, IDLE, GUARD, ERROR.
REQ-020 WARMUP: entered on reset; events ignored; after STARTUP_CYC edges -> IDLE.
REQ-021 IDLE: event accepted -> GUARD with window counter loaded to ct_cfg; ct_cfg=0 -> stay IDLE.
REQ-022 GUARD: counter decrements each edge, reaching 0 -> IDLE; event while counter nonzero is a violation.
REQ-023 Violation: offending event dropped, delay line flushed, err_cnt +1 (saturates at 255), state -> ERROR.
REQ-024 ERROR: out held, events ignored, err=1; err_clr -> IDLE next edge.
REQ-025 Event and err_clr on same edge in ERROR: event ignored, state -> IDLE.
REQ-026 Violation and err_clr on same edge: violation wins, err_cnt increments, stays ERROR.
REQ-027 Event coinciding with an output toggle edge: both take effect; no interaction.
REQ-028 busy SHALL equal OR of all delay-line bits up to MAX_DLY.

Reset
REQ-029 rst_n low SHALL immediately force out=0, err=0, err_cnt=0, busy=0, delay line empty, state WARMUP, input sample register=0.
REQ-030 Reset mid-flight SHALL discard all pending events; no toggles emitted after release for pre-reset events.
REQ-031 Release of rst_n SHALL be synchronous to clk on the first rising edge after deassertion.

Structure
REQ-032 Package mitll_sfq_pkg SHALL hold the state enum typedef, ERR_CNT_W=8, and the MAX_DLY derivation function.
REQ-033 Sub-module mitll_sfq_dline SHALL implement the MAX_DLY-deep event shift line with N_OUT tap selects and flush input.
REQ-034 Top module SHALL contain edge detect, state machine, window counter, error counter, output toggle registers.

Verification
REQ-035 Reset release, pulse in at cycle 2 -> no output toggles (WARMUP); pulse at cycle 10, dly_cfg all 3 -> all out toggle at edge 13.
REQ-036 N_OUT=4, dly_cfg={1,5,9,15}, one pulse at edge 20 -> out[0..3] toggle at edges 21,25,29,35; busy high edges 21..34.
REQ-037 ct_cfg=3, pulses at edges 20 and 22 -> second dropped, pending flushed, err=1, err_cnt=1; pulses at 20 and 23 -> both propagate.
REQ-038 In ERROR, pulse plus err_clr same edge -> pulse ignored, IDLE next edge; later pulse propagates normally.
REQ-039 300 violations -> err_cnt saturates at 255.
REQ-040 ct_cfg=0, dly 15, pulses every 2 cycles, rst_n low mid-stream -> out=0 immediately, no toggles after release until new pulses.

Source files
------------

// File: rtl/mitll_sfq_pkg.sv
// Shared types and helpers for the SFQ splitter slice: controller state
// encoding, error counter width and the delay-line depth derivation.
package mitll_sfq_pkg;

    // Width of the saturating timing-violation counter.
    localparam int ERR_CNT_W = 8;

    // Controller states.
    //   ST_WARMUP : post-reset settling, input events ignored
    //   ST_IDLE   : ready, next event is accepted
    //   ST_GUARD  : critical-timing window open after an accepted event
    //   ST_ERROR  : violation seen, outputs frozen until err_clr
    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_IDLE   = 2'd1,
        ST_GUARD  = 2'd2,
        ST_ERROR  = 2'd3
    } sfq_state_e;

    // Longest delay a DLY_W-bit field can request; also the delay-line depth.
    function automatic int max_dly(input int dly_w);
        return (1 << dly_w) - 1;
    endfunction

endpackage

// File: rtl/mitll_sfq_dline.sv
// Event shift line for the SFQ splitter. An accepted event enters at
// position 1 and advances one position per clock. Each output branch
// taps the position equal to its configured delay, so a branch with
// delay D sees the event exactly D edges after it was accepted. The
// tap select is live: the delay in force at output time is the one used.
module mitll_sfq_dline
    import mitll_sfq_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int DLY_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     flush,
    input  logic [N_OUT*DLY_W-1:0]   dly_cfg,
    output logic [N_OUT-1:0]         taps,
    output logic                     busy
);

    localparam int MAX_DLY = max_dly(DLY_W);

    // Position j holds an event accepted j-1 edges ago.
    logic [MAX_DLY:1] line;
    logic [MAX_DLY:1] line_nxt;

    // Next line contents: shift by one, insert the new event, or clear on flush.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        line_nxt    = line << 1;
        line_nxt[1] = push;
        if (flush) begin
            line_nxt = '0;
        end
    end

    // Delay-line storage.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the line is fully reset (not left to initialise itself) so events pending at reset can never emerge afterwards.
        if (!rst_n) begin
            line <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            line <= line_nxt;
        end
    end

    // Per-branch tap select; a zero delay field behaves as a delay of one.
    for (genvar g = 0; g < N_OUT; g++) begin : g_tap
        logic [DLY_W-1:0] fld;
        logic [DLY_W-1:0] sel;
        assign fld     = dly_cfg[g*DLY_W +: DLY_W];
        assign sel     = (fld == '0) ? DLY_W'(1) : fld;
        assign taps[g] = line[sel];
    end

    assign busy = |line;

endmodule

// File: rtl/mitll_splitter_n.sv
// N-way SFQ pulse splitter with per-branch programmable delay.
// The toggle-encoded input is edge-detected; each accepted event is
// replayed on every output branch after that branch's delay. A
// critical-timing guard rejects events that follow an accepted event
// too closely: the offending event is dropped, everything in flight is
// flushed, the violation is counted and the block parks in ERROR until
// software clears it.
module mitll_splitter_n
    import mitll_sfq_pkg::*;
#(
    parameter int N_OUT       = 4,   // fan-out branches, 2..16
    parameter int DLY_W       = 4,   // per-branch delay field width
    parameter int CT_W        = 4,   // critical-timing window width
    parameter int STARTUP_CYC = 4    // edges ignored after reset release
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in,
    input  logic [N_OUT*DLY_W-1:0]   dly_cfg,
    input  logic [CT_W-1:0]          ct_cfg,
    input  logic                     err_clr,
    output logic [N_OUT-1:0]         out,
    output logic                     err,
    output logic [ERR_CNT_W-1:0]     err_cnt,
    output logic                     busy
);

    // Warm-up counter runs 0 .. STARTUP_CYC-1; a zero startup still
    // spends the first edge in WARMUP because that is the reset state.
    localparam int WU_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam logic [WU_W-1:0] WU_LAST =
        WU_W'((STARTUP_CYC > 0) ? STARTUP_CYC - 1 : 0);

    sfq_state_e        state;
    logic              in_q;
    logic [WU_W-1:0]   wu_cnt;
    logic [CT_W-1:0]   win;
    logic [CT_W-1:0]   win_dec;
    logic              ev;
    logic              accept;
    logic              viol;
    logic [N_OUT-1:0]  taps;

    // A level change between consecutive samples is one SFQ pulse.
    assign ev      = in ^ in_q;
    // Window value after this edge's decrement; only meaningful in GUARD,
    // where the window counter is always at least one.
    assign win_dec = win - CT_W'(1);

    // Event classification for the current edge. In GUARD the window
    // closes on the edge where the counter reaches zero, and an event on
    // that same edge is treated as arriving in IDLE.
    always_comb begin
        accept = 1'b0;
        viol   = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = ev;
            end
            ST_GUARD: begin
                if (win_dec == '0) begin
                    accept = ev;
                end else begin
                    viol = ev;
                end
            end
            default: begin
            end
        endcase
    end

    // Controller: warm-up, guard window, error latch and violation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_WARMUP;
            wu_cnt  <= '0;
            win     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (wu_cnt == WU_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        wu_cnt <= wu_cnt + WU_W'(1);
                    end
                end
                ST_IDLE, ST_GUARD: begin
                    if (viol) begin
                        // A violation overrides any simultaneous err_clr.
                        state <= ST_ERROR;
                        err   <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end
                    end else if (accept && (ct_cfg != '0)) begin
                        state <= ST_GUARD;
                        win   <= ct_cfg;
                    end else if (state == ST_GUARD) begin
                        win <= win_dec;
                        if (win_dec == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERROR: begin
                    // Events arriving here are ignored, even alongside err_clr.
                    if (err_clr) begin
                        state <= ST_IDLE;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_WARMUP;
                end
            endcase
        end
    end

    // Input sampling and branch output toggles. Toggles are suppressed on
    // the violation edge because that edge flushes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
            out  <= '0;
        end else begin
            in_q <= in;
            if (!viol) begin
                out <= out ^ taps;
            end
        end
    end

    mitll_sfq_dline #(
        .N_OUT (N_OUT),
        .DLY_W (DLY_W)
    ) u_dline (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .flush   (viol),
        .dly_cfg (dly_cfg),
        .taps    (taps),
        .busy    (busy)
    );

endmodule

// File: tb/tb_mitll_splitter_n.sv
// Testbench for mitll_splitter_n (default parameters). Directed sequences
// use hand-derived constants; every edge is also compared against a
// behavioural model that keeps a list of accepted event times.
module tb_mitll_splitter_n;

    localparam int N_OUT   = 4;
    localparam int DLY_W   = 4;
    localparam int CT_W    = 4;
    localparam int STARTUP = 4;
    localparam int MAX_DLY = 15;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in;
    logic [N_OUT*DLY_W-1:0] dly_cfg;
    logic [CT_W-1:0]        ct_cfg;
    logic                   err_clr;
    logic [N_OUT-1:0]       out;
    logic                   err;
    logic [7:0]             err_cnt;
    logic                   busy;

    always #5 clk = ~clk;

    mitll_splitter_n #(
        .N_OUT       (N_OUT),
        .DLY_W       (DLY_W),
        .CT_W        (CT_W),
        .STARTUP_CYC (STARTUP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .dly_cfg (dly_cfg),
        .ct_cfg  (ct_cfg),
        .err_clr (err_clr),
        .out     (out),
        .err     (err),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: edges since reset release, accepted event
    // times still in flight, and the last accepted event's guard window.
    int               m_t;
    int               m_q[$];
    logic             m_prev_in;
    bit               m_err;
    bit               m_have;
    int               m_last_k;
    int               m_last_ct;
    logic [N_OUT-1:0] m_out;
    int               m_cnt;

    typedef struct {
        logic       pulse;
        logic       clr;
        logic [3:0] out;
        logic       err;
        logic [7:0] cnt;
        logic       busy;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic [3:0] out;
        logic       busy;
    } cp_t;

    vec_t tv[11];
    cp_t  cps[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_t, act, exp);
        end
    endtask

    function automatic int dval(input int i);
        logic [DLY_W-1:0] f;
        f = dly_cfg[i*DLY_W +: DLY_W];
        return (f == '0) ? 1 : int'(f);
    endfunction

    task automatic model_reset();
        m_t       = 0;
        m_q.delete();
        m_prev_in = 1'b0;
        m_err     = 1'b0;
        m_have    = 1'b0;
        m_last_k  = 0;
        m_last_ct = 0;
        m_out     = '0;
        m_cnt     = 0;
    endtask

    // One rising edge of the reference model, using the inputs now applied.
    task automatic model_edge();
        logic ev;
        ev        = (in != m_prev_in);
        m_prev_in = in;
        m_t++;
        if (m_t <= STARTUP) begin
            // warm-up: nothing accepted, nothing in flight
        end else if (m_err) begin
            if (err_clr) m_err = 1'b0;
        end else if (ev && m_have && (m_t - m_last_k) < m_last_ct) begin
            m_q.delete();
            m_err  = 1'b1;
            m_have = 1'b0;
            if (m_cnt < 255) m_cnt++;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                foreach (m_q[j]) begin
                    if (m_t - m_q[j] == dval(i)) m_out[i] = ~m_out[i];
                end
            end
            while (m_q.size() > 0 && (m_t - m_q[0]) >= MAX_DLY) void'(m_q.pop_front());
            if (ev) begin
                m_q.push_back(m_t);
                m_have    = 1'b1;
                m_last_k  = m_t;
                m_last_ct = int'(ct_cfg);
            end
        end
    endtask

    // Apply one cycle of stimulus (called just after a falling edge) and
    // compare all outputs against the model on the following falling edge.
    task automatic step(input logic pulse, input logic clr);
        in      = in ^ pulse;
        err_clr = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out",     32'(out),     32'(m_out));
        check("err",     32'(err),     32'(m_err));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
        check("busy",    32'(busy),    32'(m_q.size() > 0));
    endtask

    // Asynchronous reset pulse: outputs must clear without a clock edge.
    task automatic do_reset();
        err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out",     32'(out),     32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Guard-window sequence: ct=3, all delays 2, starting at edge 20.
        tv[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 8'd0, 1'b1};  // 20 accept
        tv[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b1};  // 21
        tv[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 8'd1, 1'b0};  // 22 violation, flush
        tv[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 8'd1, 1'b0};  // 23 held in ERROR
        tv[4]  = '{1'b0, 1'b1, 4'h0, 1'b0, 8'd1, 1'b0};  // 24 cleared
        tv[5]  = '{1'b1, 1'b0, 4'h0, 1'b0, 8'd1, 1'b1};  // 25 accept
        tv[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 8'd1, 1'b1};  // 26
        tv[7]  = '{1'b0, 1'b0, 4'hF, 1'b0, 8'd1, 1'b1};  // 27 toggle from 25
        tv[8]  = '{1'b1, 1'b0, 4'hF, 1'b0, 8'd1, 1'b1};  // 28 window closed, accept
        tv[9]  = '{1'b0, 1'b0, 4'hF, 1'b0, 8'd1, 1'b1};  // 29
        tv[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 8'd1, 1'b1};  // 30 toggle from 28

        // Staggered delays {15,9,5,1}, single pulse at edge 20.
        cps[0] = '{20, 4'b0000, 1'b1};
        cps[1] = '{21, 4'b0001, 1'b1};
        cps[2] = '{24, 4'b0001, 1'b1};
        cps[3] = '{25, 4'b0011, 1'b1};
        cps[4] = '{28, 4'b0011, 1'b1};
        cps[5] = '{29, 4'b0111, 1'b1};
        cps[6] = '{34, 4'b0111, 1'b1};
        cps[7] = '{35, 4'b1111, 1'b0};
        cps[8] = '{36, 4'b1111, 1'b0};

        rst_n   = 1'b1;
        in      = 1'b0;
        err_clr = 1'b0;
        dly_cfg = 16'h3333;
        ct_cfg  = 4'd0;
        model_reset();
        do_reset();

        // Warm-up drops the pulse at edge 2; pulse at 10 emerges at 13.
        for (int e = 1; e <= 14; e++) begin
            step(e == 2 || e == 10, 1'b0);
            if (e == 2)  check("warmup_ignored", 32'(busy), 32'd0);
            if (e == 10) check("accept_busy",    32'(busy), 32'd1);
            if (e == 12) check("dly3_before",    32'(out),  32'h0);
            if (e == 13) check("dly3_toggle",    32'(out),  32'hF);
        end

        // Per-branch delays.
        dly_cfg = 16'hF951;
        do_reset();
        for (int e = 1; e <= 36; e++) begin
            step(e == 20, 1'b0);
            for (int j = 0; j < 9; j++) begin
                if (cps[j].edge_n == e) begin
                    check("stagger_out",  32'(out),  32'(cps[j].out));
                    check("stagger_busy", 32'(busy), 32'(cps[j].busy));
                end
            end
        end

        // Guard window, violation, clear, re-accept.
        dly_cfg = 16'h2222;
        ct_cfg  = 4'd3;
        do_reset();
        for (int e = 1; e <= 19; e++) step(1'b0, 1'b0);
        for (int r = 0; r < 11; r++) begin
            step(tv[r].pulse, tv[r].clr);
            check("tv_out",     32'(out),     32'(tv[r].out));
            check("tv_err",     32'(err),     32'(tv[r].err));
            check("tv_err_cnt", 32'(err_cnt), 32'(tv[r].cnt));
            check("tv_busy",    32'(busy),    32'(tv[r].busy));
        end
        for (int e = 31; e <= 49; e++) step(1'b0, 1'b0);

        // Violation beats err_clr; then pulse+err_clr in ERROR is ignored.
        step(1'b1, 1'b0);                               // 50 accept
        step(1'b1, 1'b1);                               // 51 violation + clr
        check("viol_wins_err", 32'(err),     32'd1);
        check("viol_wins_cnt", 32'(err_cnt), 32'd2);
        step(1'b1, 1'b1);                               // 52 pulse + clr in ERROR
        check("clr_err",       32'(err),  32'd0);
        check("clr_drop_busy", 32'(busy), 32'd0);
        check("clr_drop_out",  32'(out),  32'h0);
        step(1'b1, 1'b0);                               // 53 accept
        step(1'b0, 1'b0);                               // 54
        check("post_clr_hold", 32'(out), 32'h0);
        step(1'b0, 1'b0);                               // 55
        check("post_clr_tgl",  32'(out), 32'hF);

        // Error counter saturation.
        dly_cfg = 16'h3333;
        ct_cfg  = 4'd2;
        do_reset();
        repeat (STARTUP) step(1'b0, 1'b0);
        for (int v = 1; v <= 300; v++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
            if (v == 200) check("cnt_200", 32'(err_cnt), 32'd200);
        end
        check("cnt_sat", 32'(err_cnt), 32'd255);

        // Reset in the middle of a pulse stream.
        dly_cfg = 16'hFFFF;
        ct_cfg  = 4'd0;
        do_reset();
        for (int e = 1; e <= 30; e++) step(e >= 10 && (e % 2) == 0, 1'b0);
        check("stream_out", 32'(out),  32'hF);
        check("stream_busy", 32'(busy), 32'd1);
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            step(e == 10, 1'b0);
            if (e == 24) check("post_rst_quiet", 32'(out), 32'h0);
            if (e == 25) check("post_rst_new",   32'(out), 32'hF);
        end

        // Randomised traffic against the model.
        for (int b = 0; b < 6; b++) begin
            dly_cfg = 16'($urandom);
            ct_cfg  = 4'($urandom_range(0, 6));
            if (b == 3) do_reset();
            for (int c = 0; c < 300; c++) begin
                if (c % 50 == 49) ct_cfg = 4'($urandom_range(0, 6));
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
